// File: rtl/dff_pipe.sv
// Parameterised register pipeline with per-stage valid bits, flush and optional bubble collapsing.
// Stage 0 faces the input; stage DEPTH-1 drives q/q_valid straight from its registers.
`timescale 1ns / 1ps

module dff_pipe #(
  parameter int unsigned      WIDTH     = 8,
  parameter int unsigned      DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter bit               COLLAPSE  = 1'b0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       en,
  input  logic                       flush,
  input  logic                       d_valid,
  input  logic [WIDTH-1:0]           d,
  output logic                       d_ready,
  output logic                       q_valid,
  output logic [WIDTH-1:0]           q,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int unsigned OccW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] dat_q [DEPTH];
  logic [DEPTH-1:0] v_q;
  logic [DEPTH-1:0] rdy;
  logic             full_tail;

  // A stage may move when the output drains, or (collapsing) when any stage from it to the
  // output holds a bubble. Written as a suffix-AND to avoid a self-referencing comb chain.
  always_comb begin
    rdy       = '0;
    full_tail = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      full_tail = 1'b1;
      for (int j = k; j < DEPTH; j++) begin
        full_tail = full_tail & v_q[j];
      end
      rdy[k] = en | (COLLAPSE & ~full_tail);
    end
  end

  assign d_ready = rdy[0] & ~flush & ~reset;
  assign q       = dat_q[DEPTH-1];
  assign q_valid = v_q[DEPTH-1];

  always_comb begin
    occupancy = '0;
    for (int k = 0; k < DEPTH; k++) begin
      occupancy = occupancy + OccW'(v_q[k]);
    end
  end

  // Flush kills valids but leaves data in place; data shifts regardless of valid bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        dat_q[k] <= RESET_VAL;
      end
      v_q <= '0;
    end else if (flush) begin
      v_q <= '0;
    end else begin
      if (rdy[0]) begin
        dat_q[0] <= d;
        v_q[0]   <= d_valid;
      end
      for (int k = 1; k < DEPTH; k++) begin
        if (rdy[k]) begin
          dat_q[k] <= dat_q[k-1];
          v_q[k]   <= v_q[k-1];
        end
      end
    end
  end

endmodule

// File: doc/dff_pipe.md
DFF_PIPE -- requirements
Module: dff_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data width in bits (1..64).
REQ-002 SHALL have parameter DEPTH, default 4, number of register stages (1..16).
REQ-003 SHALL have parameter RESET_VAL, default 0, WIDTH-bit value loaded into every stage data register on reset.
REQ-004 SHALL have parameter COLLAPSE, default 0: 0 = rigid pipeline, 1 = bubble-collapsing pipeline.
REQ-005 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port en  input  1  advance enable / downstream accept; 1 = final stage may drain.
REQ-008 SHALL have port flush  input  1  synchronous invalidate of all stages.
REQ-009 SHALL have port d_valid  input  1  input word valid.
REQ-010 SHALL have port d  input  WIDTH  input data.
REQ-011 SHALL have port d_ready  output  1  input word accepted this edge when d_valid=1.
REQ-012 SHALL have port q_valid  output  1  valid bit of stage DEPTH-1.
REQ-013 SHALL have port q  output  WIDTH  data of stage DEPTH-1.
REQ-014 SHALL have port occupancy  output  $clog2(DEPTH+1)  count of valid stages.

Function
REQ-015 SHALL hold per stage k (0..DEPTH-1) a WIDTH-bit data register dat[k] and a valid bit v[k]; stage 0 is input side.
REQ-016 SHALL drive q = dat[DEPTH-1], q_valid = v[DEPTH-1] directly from registers, no combinational path from d.
REQ-017 SHALL compute per-stage move signal rdy[k]: COLLAPSE=0 -> rdy[k] = en for all k; COLLAPSE=1 -> rdy[DEPTH-1] = en | ~v[DEPTH-1], rdy[k] = rdy[k+1] | ~v[k] for k < DEPTH-1.
REQ-018 SHALL drive d_ready = rdy[0] (combinational from registers and en).
REQ-019 SHALL, on an edge with rdy[k]=1 and no reset/flush, load dat[k] <= dat[k-1], v[k] <= v[k-1] for k>=1, and dat[0] <= d, v[0] <= d_valid.
REQ-020 SHALL hold dat[k] and v[k] unchanged on an edge with rdy[k]=0.
REQ-021 SHALL shift data registers regardless of valid bits (invalid stages carry don't-care data).
REQ-022 SHALL give latency exactly DEPTH edges from d_valid=1 with d_ready=1 to q_valid=1 when en held 1.
REQ-023 SHALL count a word as delivered on an edge where q_valid=1 and en=1.
REQ-024 SHALL, with flush=1 (reset=0), clear every v[k] to 0, leave dat[k] unchanged, discard the input word, and force d_ready=0 that cycle.
REQ-025 SHALL give reset priority over flush, flush over en/d_valid.
REQ-026 SHALL compute occupancy as popcount of v[0..DEPTH-1], combinational from registers.
REQ-027 SHALL, with DEPTH=1 and COLLAPSE=0, behave as a single enabled DFF with synchronous reset and valid bit.
REQ-028 SHALL in COLLAPSE=1 never overwrite a valid stage whose successor is not moving (no data loss under en=0).

Reset
REQ-029 SHALL, on an edge with reset=1, set all dat[k] = RESET_VAL and all v[k] = 0, regardless of en, flush, d_valid.
REQ-030 SHALL present q = RESET_VAL, q_valid = 0, occupancy = 0 from the first edge after reset until new data arrives; reset asserted mid-stream drops all in-flight words.

Verification
REQ-031 SHALL verify: WIDTH=8, DEPTH=4, COLLAPSE=0, en=1, d_valid=1, d=0x11,0x22,0x33 on consecutive edges -> q=0x11 with q_valid=1 on 4th edge, then 0x22, 0x33, then q_valid=0.
REQ-032 SHALL verify: COLLAPSE=0, pipeline holding 0x11..0x44 all valid, en=0 for 3 edges -> q=0x44, occupancy=4, d_ready=0 throughout, no change.
REQ-033 SHALL verify: COLLAPSE=1, v=[1,0,1,1] (stage0..3), en=0, d_valid=1, d=0x55 -> d_ready=1; next edge v=[1,1,1,1], occupancy=4, q unchanged; then d_ready=0.
REQ-034 SHALL verify: 3 valid words in flight, flush=1 and d_valid=1 same edge -> occupancy=0, q_valid=0, d_ready=0 during flush, dat unchanged.
REQ-035 SHALL verify: RESET_VAL=0xA5, reset=1 mid-stream together with flush=1 and d_valid=1 -> next edge q=0xA5, q_valid=0, occupancy=0.
REQ-036 SHALL verify: DEPTH=1, d toggling every 15 ns, clk period 20 ns, en=1 -> q equals d sampled at each rising edge, reset=1 at an edge forces q=RESET_VAL.
